// File: rtl/sweep_sched.sv
// Frequency sweep sequencer for the DDS learning mode.
// Steps freq_ctrl from START_FREQ to STOP_FREQ. At each point it waits a settle time, then runs a measurement handshake.
module sweep_sched #(
    parameter int unsigned FREQ_W       = 16,
    parameter int unsigned IDLE_FREQ    = 1,
    parameter int unsigned START_FREQ   = 4,
    parameter int unsigned STOP_FREQ    = 100,
    parameter int unsigned STEP_FREQ    = 1,
    parameter int unsigned SETTLE_CYC   = 50000,
    parameter int unsigned MEAS_TIMEOUT = 5000000
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              meas_done,
    output logic [FREQ_W-1:0] freq_ctrl,
    output logic              meas_start,
    output logic              busy,
    output logic              done,
    output logic [FREQ_W-1:0] step_idx,
    output logic              timeout_err
);

    localparam int unsigned SUM_W    = FREQ_W + 1;
    localparam int unsigned SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned TMO_W    = (MEAS_TIMEOUT > 1) ? $clog2(MEAS_TIMEOUT) : 1;

    localparam logic [FREQ_W-1:0]   IDLE_F      = FREQ_W'(IDLE_FREQ);
    localparam logic [FREQ_W-1:0]   START_F     = FREQ_W'(START_FREQ);
    localparam logic [SUM_W-1:0]    STEP_S      = SUM_W'(STEP_FREQ);
    localparam logic [SUM_W-1:0]    STOP_S      = SUM_W'(STOP_FREQ);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(MEAS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEAS,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [SUM_W-1:0]    sum;

    // One extra bit catches wrap past the top of the frequency word.
    always_comb begin
        sum = {1'b0, freq_ctrl} + STEP_S;
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state       <= S_IDLE;
            freq_ctrl   <= IDLE_F;
            meas_start  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            step_idx    <= '0;
            timeout_err <= 1'b0;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
        end else begin
            meas_start <= 1'b0;
            done       <= 1'b0;
            if (abort && state != S_IDLE) begin
                state     <= S_IDLE;
                freq_ctrl <= IDLE_F;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            freq_ctrl   <= START_F;
                            step_idx    <= '0;
                            timeout_err <= 1'b0;
                            settle_cnt  <= '0;
                            busy        <= 1'b1;
                            state       <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                        if (settle_cnt == SETTLE_LAST) begin
                            meas_start <= 1'b1;
                            tmo_cnt    <= '0;
                            state      <= S_MEAS;
                        end
                    end
                    S_MEAS: begin
                        // A completion arriving on the timeout cycle still counts as good.
                        if (meas_done) begin
                            state <= S_NEXT;
                        end else if (tmo_cnt == TMO_LAST) begin
                            timeout_err <= 1'b1;
                            state       <= S_NEXT;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    S_NEXT: begin
                        if (sum[FREQ_W] || sum > STOP_S) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            freq_ctrl  <= sum[FREQ_W-1:0];
                            step_idx   <= step_idx + FREQ_W'(1);
                            settle_cnt <= '0;
                            state      <= S_SETTLE;
                        end
                    end
                    S_DONE: begin
                        freq_ctrl <= IDLE_F;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                    default: begin
                        freq_ctrl <= IDLE_F;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sweep_sched.sv
// Scoreboard bench for sweep_sched.
// The main instance runs the normal, timeout, abort, random and reset cases. Two more instances cover the top-of-range and start>stop cases.
`timescale 1ns/1ps
module tb_sweep_sched;

    localparam logic [15:0] IDLE_F = 16'd1;

    typedef struct packed {
        logic [15:0] f;
        logic [15:0] idx;
        logic        terr;
    } pt_t;

    logic clk_50m = 1'b0;
    logic rst     = 1'b1;
    always #10 clk_50m = ~clk_50m;

    logic        tb_start, rnd_start, tb_abort, resp_done, rnd_done;
    logic        start0, meas_done0;
    logic [15:0] freq0, idx0;
    logic        ms0, busy0, done0, terr0;
    logic        start1, ms1, busy1, done1, terr1;
    logic [15:0] freq1, idx1;
    logic        start2, ms2, busy2, done2, terr2;
    logic [15:0] freq2, idx2;

    assign start0     = tb_start | rnd_start;
    assign meas_done0 = resp_done | rnd_done;

    int  n_tests = 0;
    int  n_fail  = 0;
    pt_t exp_q[$];
    pt_t aux_q[$];
    bit  resp_en = 1'b0;
    bit  rnd_en  = 1'b0;
    bit  in_meas = 1'b0;
    int  exp_hold = 4;
    int  done_cnt = 0;
    int  ms_cnt   = 0;

    sweep_sched #(.FREQ_W(16), .IDLE_FREQ(1), .START_FREQ(4), .STOP_FREQ(7), .STEP_FREQ(1),
                  .SETTLE_CYC(3), .MEAS_TIMEOUT(10)) u_main (
        .clk_50m(clk_50m), .rst(rst), .start(start0), .abort(tb_abort), .meas_done(meas_done0),
        .freq_ctrl(freq0), .meas_start(ms0), .busy(busy0), .done(done0), .step_idx(idx0),
        .timeout_err(terr0));

    sweep_sched #(.FREQ_W(16), .IDLE_FREQ(1), .START_FREQ(32'hFFFE), .STOP_FREQ(32'hFFFF),
                  .STEP_FREQ(1), .SETTLE_CYC(3), .MEAS_TIMEOUT(10)) u_top (
        .clk_50m(clk_50m), .rst(rst), .start(start1), .abort(1'b0), .meas_done(1'b0),
        .freq_ctrl(freq1), .meas_start(ms1), .busy(busy1), .done(done1), .step_idx(idx1),
        .timeout_err(terr1));

    sweep_sched #(.FREQ_W(16), .IDLE_FREQ(1), .START_FREQ(8), .STOP_FREQ(5), .STEP_FREQ(1),
                  .SETTLE_CYC(3), .MEAS_TIMEOUT(10)) u_inv (
        .clk_50m(clk_50m), .rst(rst), .start(start2), .abort(1'b0), .meas_done(1'b0),
        .freq_ctrl(freq2), .meas_start(ms2), .busy(busy2), .done(done2), .step_idx(idx2),
        .timeout_err(terr2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Queue the points of one sweep from START=4; points after the first carry terr_after.
    task automatic push_pts(input int n, input bit terr_after);
        pt_t p;
        for (int i = 0; i < n; i++) begin
            p.f    = 16'(4 + i);
            p.idx  = 16'(i);
            p.terr = (i == 0) ? 1'b0 : terr_after;
            exp_q.push_back(p);
        end
    endtask

    task automatic pulse_start();
        tb_start = 1'b1;
        @(negedge clk_50m);
        tb_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk_50m);
            if (done0) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_freq"}, 32'(freq0), 32'(IDLE_F));
        check({tag, "_ms"}, 32'(ms0), 32'd0);
        check({tag, "_busy"}, 32'(busy0), 32'd0);
        check({tag, "_done"}, 32'(done0), 32'd0);
        check({tag, "_idx"}, 32'(idx0), 32'd0);
        check({tag, "_terr"}, 32'(terr0), 32'd0);
    endtask

    // The auxiliary instances never see meas_done, so every point times out.
    task automatic run_aux(input int k);
        bit          got_done  = 1'b0;
        bit          zero_seen = 1'b0;
        pt_t         e;
        logic [15:0] f, ix;
        logic        m, d, b, t;
        if (k == 0) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk_50m);
        start1 = 1'b0;
        start2 = 1'b0;
        for (int c = 0; c < 300 && !got_done; c++) begin
            @(negedge clk_50m);
            f  = (k == 0) ? freq1 : freq2;
            ix = (k == 0) ? idx1 : idx2;
            m  = (k == 0) ? ms1 : ms2;
            d  = (k == 0) ? done1 : done2;
            if (f == 16'd0) zero_seen = 1'b1;
            if (m) begin
                if (aux_q.size() == 0) begin
                    check("aux_extra_ms", 32'(m), 32'd0);
                end else begin
                    e = aux_q.pop_front();
                    check("aux_freq", 32'(f), 32'(e.f));
                    check("aux_idx", 32'(ix), 32'(e.idx));
                end
            end
            if (d) got_done = 1'b1;
        end
        check("aux_done_seen", 32'(got_done), 32'd1);
        check("aux_pts_left", 32'(aux_q.size()), 32'd0);
        @(negedge clk_50m);
        f = (k == 0) ? freq1 : freq2;
        b = (k == 0) ? busy1 : busy2;
        t = (k == 0) ? terr1 : terr2;
        check("aux_idle_freq", 32'(f), 32'(IDLE_F));
        check("aux_busy", 32'(b), 32'd0);
        check("aux_terr", 32'(t), 32'd1);
        check("aux_no_wrap", 32'(zero_seen), 32'd0);
    endtask

    // Monitor for the main instance: settle latency, point scoreboard, hold time, done/busy.
    initial begin
        logic [15:0] prev_f = 16'd1;
        int          age    = 0;
        int          ms_age = 0;
        bit          pend_busy = 1'b0;
        pt_t         e;
        forever begin
            @(negedge clk_50m);
            age++;
            ms_age++;
            if (pend_busy) begin
                check("busy_after_done", 32'(busy0), 32'd0);
                pend_busy = 1'b0;
            end
            if (freq0 != prev_f) begin
                if (freq0 != IDLE_F && prev_f != IDLE_F)
                    check("meas_hold", 32'(ms_age), 32'(exp_hold));
                age     = 0;
                in_meas = 1'b0;
                prev_f  = freq0;
            end
            if (ms0) begin
                ms_cnt++;
                check("settle_cycles", 32'(age), 32'd3);
                if (exp_q.size() == 0) begin
                    check("unexpected_ms", 32'(ms0), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pt_freq", 32'(freq0), 32'(e.f));
                    check("pt_idx", 32'(idx0), 32'(e.idx));
                    check("pt_terr", 32'(terr0), 32'(e.terr));
                end
                ms_age  = 0;
                in_meas = 1'b1;
            end
            if (done0) begin
                done_cnt++;
                pend_busy = 1'b1;
                in_meas   = 1'b0;
            end
        end
    end

    // Measurement block model: answers each meas_start two cycles later.
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk_50m);
            if (resp_en && ms0) begin
                repeat (2) @(negedge clk_50m);
                resp_done = 1'b1;
                @(negedge clk_50m);
                resp_done = 1'b0;
            end
        end
    end

    // Random stray start pulses while busy, and meas_done pulses outside MEAS.
    initial begin
        rnd_start = 1'b0;
        rnd_done  = 1'b0;
        forever begin
            @(negedge clk_50m);
            #1;
            rnd_start = 1'b0;
            rnd_done  = 1'b0;
            if (rnd_en && busy0) begin
                if ($urandom_range(3) == 0) rnd_start = 1'b1;
                if (!in_meas && !ms0 && $urandom_range(2) == 0) rnd_done = 1'b1;
            end
        end
    end

    initial begin
        bit seen;
        int dc, mc;
        tb_start = 1'b0;
        tb_abort = 1'b0;
        start1   = 1'b0;
        start2   = 1'b0;
        repeat (3) @(negedge clk_50m);
        check_reset_vals("por");
        check("por_freq_top", 32'(freq1), 32'(IDLE_F));
        check("por_freq_inv", 32'(freq2), 32'(IDLE_F));
        rst = 1'b0;
        @(negedge clk_50m);

        // Normal sweep with answered measurements.
        resp_en  = 1'b1;
        exp_hold = 4;
        push_pts(4, 1'b0);
        dc = done_cnt;
        pulse_start();
        check("t1_busy", 32'(busy0), 32'd1);
        wait_done(200);
        @(negedge clk_50m);
        check("t1_idle_freq", 32'(freq0), 32'(IDLE_F));
        check("t1_done_cnt", 32'(done_cnt - dc), 32'd1);
        check("t1_terr", 32'(terr0), 32'd0);
        check("t1_pts_left", 32'(exp_q.size()), 32'd0);

        // Every point times out.
        resp_en  = 1'b0;
        exp_hold = 11;
        push_pts(4, 1'b1);
        dc = done_cnt;
        pulse_start();
        wait_done(300);
        @(negedge clk_50m);
        check("t2_terr_sticky", 32'(terr0), 32'd1);
        check("t2_idle_freq", 32'(freq0), 32'(IDLE_F));
        check("t2_done_cnt", 32'(done_cnt - dc), 32'd1);
        check("t2_pts_left", 32'(exp_q.size()), 32'd0);

        // Abort during MEAS of point 5, then restart.
        repeat (3) @(negedge clk_50m);
        check("t3_terr_held", 32'(terr0), 32'd1);
        resp_en  = 1'b1;
        exp_hold = 4;
        push_pts(2, 1'b0);
        dc   = done_cnt;
        seen = 1'b0;
        pulse_start();
        for (int c = 0; c < 200 && !seen; c++) begin
            if (ms0 && freq0 == 16'd5) seen = 1'b1;
            else @(negedge clk_50m);
        end
        check("t3_reach_pt5", 32'(seen), 32'd1);
        tb_abort = 1'b1;
        @(negedge clk_50m);
        tb_abort = 1'b0;
        check("t3_abort_freq", 32'(freq0), 32'(IDLE_F));
        check("t3_abort_busy", 32'(busy0), 32'd0);
        check("t3_abort_done", 32'(done0), 32'd0);
        repeat (10) @(negedge clk_50m);
        check("t3_no_done", 32'(done_cnt - dc), 32'd0);
        check("t3_pts_left", 32'(exp_q.size()), 32'd0);
        push_pts(4, 1'b0);
        dc = done_cnt;
        pulse_start();
        wait_done(200);
        @(negedge clk_50m);
        check("t3_restart_done", 32'(done_cnt - dc), 32'd1);
        check("t3_restart_left", 32'(exp_q.size()), 32'd0);

        // Stray start and meas_done pulses while busy.
        rnd_en = 1'b1;
        push_pts(4, 1'b0);
        dc = done_cnt;
        pulse_start();
        wait_done(400);
        rnd_en = 1'b0;
        @(negedge clk_50m);
        check("t4_done_cnt", 32'(done_cnt - dc), 32'd1);
        check("t4_pts_left", 32'(exp_q.size()), 32'd0);
        check("t4_terr", 32'(terr0), 32'd0);
        repeat (3) @(negedge clk_50m);

        // Reset in the middle of SETTLE.
        mc = ms_cnt;
        pulse_start();
        @(negedge clk_50m);
        check("t5_in_settle", 32'(freq0), 32'd4);
        rst = 1'b1;
        @(negedge clk_50m);
        rst = 1'b0;
        check_reset_vals("t5_rst");
        repeat (12) @(negedge clk_50m);
        check("t5_no_ms", 32'(ms_cnt - mc), 32'd0);
        check("t5_idle_busy", 32'(busy0), 32'd0);

        // Top of the 16-bit range, then start beyond stop.
        aux_q.push_back('{f: 16'hFFFE, idx: 16'd0, terr: 1'b0});
        aux_q.push_back('{f: 16'hFFFF, idx: 16'd1, terr: 1'b0});
        run_aux(0);
        aux_q.push_back('{f: 16'd8, idx: 16'd0, terr: 1'b0});
        run_aux(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
